branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
Parametrised next-generation direction/target predictor for the compute-unit fetch stage.
- Conditional branches: tagged gshare table of CTR_BITS-wide saturating counters, indexed by PC XOR a speculative global history register (GHR).
- Indirect jumps (JALR): tagged branch target buffer (BTB).
- Misprediction recovery: EX returns the history snapshot taken at prediction time, and the block restores the GHR from it.
- Sits between fetch/decode (combinational query) and EX (resolved update).

Parameters:
ENTRIES, 256, number of direction-table entries (power of 2, ≥2); IDX_BITS = $clog2(ENTRIES)
GHR_BITS, 8, global history length (1..IDX_BITS)
CTR_BITS, 2, saturating counter width (2..4)
TAG_BITS, 10, partial tag width for both tables
BTB_ENTRIES, 16, JALR target-buffer entries (power of 2, ≥2); BIDX = $clog2(BTB_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
query_valid  in  1  qualifies query; also acts as the fetch-accepted strobe that advances the GHR
query_ctrl  in  isa_pkg::decode_ctrl_t  decoded control (is_branch, funct3, imm)
query_pc  in  32  PC of the queried instruction
pred_taken  out  1  predicted taken
pred_target  out  32  predicted target
pred_ghr  out  GHR_BITS  GHR value used for this prediction; pipelined to EX by the caller
update_valid  in  1  resolved control-flow instruction in EX
update_ctrl  in  isa_pkg::decode_ctrl_t  its decoded control
update_pc  in  32  its PC
update_taken  in  1  resolved direction
update_target  in  32  resolved target (used for JALR)
update_ghr  in  GHR_BITS  pred_ghr captured at prediction time
update_mispredict  in  1  direction or target mispredicted; triggers GHR recovery

Behaviour:
Classification, identical for query and update:
- is_branch && funct3==3'b011 -> JAL.
- is_branch && funct3==3'b010 -> JALR.
- Any other is_branch -> conditional.
- !is_branch -> not control flow.

Index and tag:
- Direction index = pc[2 +: IDX_BITS] XOR zero-extended GHR.
- Direction tag = pc[2+IDX_BITS +: TAG_BITS].
- BTB index = pc[2 +: BIDX]; BTB tag = pc[2+BIDX +: TAG_BITS].

Query (purely combinational, zero latency):
- Defaults: pred_taken=0, pred_target=0. pred_ghr = current GHR at all times.
- JAL: taken=1; target = query_pc + imm.
- Conditional: target = query_pc + imm. On tag hit (valid and tag match), taken = counter MSB; on miss, taken=0.
- JALR: on BTB hit, taken=1 and target = stored target; on miss, taken=0 and target=0.
- query_valid=0 -> outputs at defaults (pred_ghr still driven).

GHR (register, one-cycle update):
- Priority 1: update_valid && update_mispredict.
  - Conditional: GHR <= {update_ghr[GHR_BITS-2:0], update_taken} (for GHR_BITS=1, GHR <= update_taken).
  - Non-conditional: GHR <= update_ghr.
  - The same-cycle query's speculative shift is discarded.
- Priority 2: query_valid && conditional -> GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- JAL/JALR never shift the GHR.

Direction-table update (takes effect next edge, on update_valid && conditional):
- Index is computed with update_ghr, not the live GHR.
- Miss: allocate valid=1, write the tag, counter = taken ? weak-taken (1 followed by zeros) : weak-not-taken (0 followed by ones).
- Hit: counter saturating +1 if taken, −1 if not; it holds at all-ones and at zero.

BTB update (on update_valid && JALR && update_taken):
- Write valid=1, tag, target = update_target. This overwrites any existing entry; there is no replacement policy.

Same-cycle query and update to the same entry:
- The query sees the pre-update value; no bypass.

Reset (while rst=1, on each edge):
- All valid bits in both tables cleared.
- Counters set to weak-not-taken; tags and targets set to 0.
- GHR = 0.
- Outputs are then pred_taken=0, pred_target=0, pred_ghr=0.
- Reset asserted mid-operation has the same effect; any update presented during a reset cycle is dropped.

Decomposition:
- isa_pkg (existing): decode_ctrl_t; add localparams FUNCT3_JAL=3'b011 and FUNCT3_JALR=3'b010.
- In-module typedefs: dir_entry_t {valid, tag, ctr} and btb_entry_t {valid, tag, target}.
- One sub-module, sat_counter_update (combinational, parametrised width): inputs counter and taken; outputs the next counter value.

Test Plan (defaults unless noted):
- Reset, then query a conditional at pc=0x100, imm=0x40 -> pred_taken=0, pred_target=0x140, pred_ghr=0; JAL at the same pc -> taken=1, target=0x140, GHR unchanged.
- Training: update the conditional at pc=0x100 with update_ghr=0 and taken=1, three times.
  - After update 1: counter=2'b10; query with GHR=0 -> taken=1.
  - After updates 2 and 3: counter saturates at 2'b11.
  - Then 3 not-taken updates -> 2'b10, 2'b01, 2'b00.
- GHR speculation: with GHR=0, issue queries for conditionals at pc=0x100 (predicted taken) and pc=0x200 (predicted not-taken) -> GHR=8'b01 and then 8'b10.
- Recovery: with GHR=8'b10, drive update_mispredict=1, update_ghr=8'h05, update_taken=0, plus a same-cycle conditional query -> next GHR=8'h0A and the query's shift is dropped.
- JALR BTB: update pc=0x300, taken=1, target=0x8000 -> query pc=0x300 gives taken=1, target=0x8000. Query pc=0x300+(16<<2) (same index, different tag) -> taken=0. Same-cycle query and update to pc=0x300 -> the query sees the old entry.
- Tag alias: train pc=0x100, then update pc=0x100+(256<<2) with ghr=0 -> the entry is reallocated and the original PC misses (taken=0). Assert rst for 1 cycle mid-stream -> all queries miss and GHR=0.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
// Control-flow classification shared by the predictor's query and update paths.
package branch_predictor_gshare_pkg;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_COND = 2'd1,
    CF_JAL  = 2'd2,
    CF_JALR = 2'd3
  } cf_kind_t;

  function automatic cf_kind_t classify_cf(input isa_pkg::decode_ctrl_t ctrl);
    cf_kind_t kind;
    if (ctrl.is_branch) begin
      case (ctrl.funct3)
        isa_pkg::FUNCT3_JAL:  kind = CF_JAL;
        isa_pkg::FUNCT3_JALR: kind = CF_JALR;
        default:              kind = CF_COND;
      endcase
    end else begin
      kind = CF_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/isa_pkg.sv
// Shared ISA decode types for the compute-unit front end.
// Also holds the funct3 encodings that single out JAL and JALR among branches.
package isa_pkg;

  typedef struct packed {
    logic        is_branch;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } decode_ctrl_t;

  localparam logic [2:0] FUNCT3_JAL  = 3'b011;
  localparam logic [2:0] FUNCT3_JALR = 3'b010;

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-side query and EX-side update bundle of the branch predictor.
interface branch_predictor_gshare_if #(
  parameter int GHR_BITS = 8
);

  logic                   query_valid;
  isa_pkg::decode_ctrl_t  query_ctrl;
  logic [31:0]            query_pc;
  logic                   pred_taken;
  logic [31:0]            pred_target;
  logic [GHR_BITS-1:0]    pred_ghr;

  logic                   update_valid;
  isa_pkg::decode_ctrl_t  update_ctrl;
  logic [31:0]            update_pc;
  logic                   update_taken;
  logic [31:0]            update_target;
  logic [GHR_BITS-1:0]    update_ghr;
  logic                   update_mispredict;

  modport master (
    output query_valid, query_ctrl, query_pc,
    output update_valid, update_ctrl, update_pc, update_taken,
    output update_target, update_ghr, update_mispredict,
    input  pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  query_valid, query_ctrl, query_pc,
    input  update_valid, update_ctrl, update_pc, update_taken,
    input  update_target, update_ghr, update_mispredict,
    output pred_taken, pred_target, pred_ghr
  );

endinterface

// File: rtl/branch_predictor_gshare_sat_counter.sv
// Next value of a saturating up/down counter: +1 on taken, -1 on not-taken.
module sat_counter_update #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr,
  input  logic             taken,
  output logic [WIDTH-1:0] ctr_next
);

  // Saturating step; holds at all-ones and at zero.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != {WIDTH{1'b1}}) begin
        ctr_next = ctr + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        ctr_next = ctr;
      end
    end else begin
      if (ctr != {WIDTH{1'b0}}) begin
        ctr_next = ctr - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        ctr_next = ctr;
      end
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with tagged counters plus a tagged JALR target buffer.
// Queries are combinational; tables and global history change only on the clock edge.
module branch_predictor_gshare
  import isa_pkg::*;
  import branch_predictor_gshare_pkg::*;
#(
  parameter int ENTRIES     = 256,
  parameter int GHR_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int TAG_BITS    = 10,
  parameter int BTB_ENTRIES = 16
) (
  input logic                      clk,
  input logic                      rst,
  branch_predictor_gshare_if.slave bp
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int BIDX     = $clog2(BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [CTR_BITS-1:0] ctr;
  } dir_entry_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
  } btb_entry_t;

  dir_entry_t          dir_tbl_r [ENTRIES];
  btb_entry_t          btb_tbl_r [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr_r;
  logic [GHR_BITS-1:0] ghr_next_s;

  cf_kind_t            q_kind_s;
  cf_kind_t            u_kind_s;
  logic [IDX_BITS-1:0] q_idx_s;
  logic [IDX_BITS-1:0] u_idx_s;
  logic [TAG_BITS-1:0] q_tag_s;
  logic [TAG_BITS-1:0] u_tag_s;
  logic [BIDX-1:0]     q_bidx_s;
  logic [BIDX-1:0]     u_bidx_s;
  logic [TAG_BITS-1:0] q_btag_s;
  logic [TAG_BITS-1:0] u_btag_s;
  dir_entry_t          q_dir_s;
  dir_entry_t          u_dir_s;
  btb_entry_t          q_btb_s;
  logic                q_hit_s;
  logic                u_hit_s;
  logic                q_bhit_s;
  logic [31:0]         q_rel_target_s;
  logic [CTR_BITS-1:0] u_ctr_next_s;
  logic [GHR_BITS:0]   q_shift_s;
  logic [GHR_BITS:0]   u_shift_s;
  logic                pred_taken_s;
  logic [31:0]         pred_target_s;
  logic                upd_dir_s;
  logic                upd_btb_s;
  logic                unused_s;

  // Classify, index and tag both ports, and read the addressed entries.
  always_comb begin
    q_kind_s       = classify_cf(bp.query_ctrl);
    u_kind_s       = classify_cf(bp.update_ctrl);
    q_idx_s        = bp.query_pc[2 +: IDX_BITS] ^ IDX_BITS'(ghr_r);
    u_idx_s        = bp.update_pc[2 +: IDX_BITS] ^ IDX_BITS'(bp.update_ghr);
    q_tag_s        = bp.query_pc[2+IDX_BITS +: TAG_BITS];
    u_tag_s        = bp.update_pc[2+IDX_BITS +: TAG_BITS];
    q_bidx_s       = bp.query_pc[2 +: BIDX];
    u_bidx_s       = bp.update_pc[2 +: BIDX];
    q_btag_s       = bp.query_pc[2+BIDX +: TAG_BITS];
    u_btag_s       = bp.update_pc[2+BIDX +: TAG_BITS];
    q_dir_s        = dir_tbl_r[q_idx_s];
    u_dir_s        = dir_tbl_r[u_idx_s];
    q_btb_s        = btb_tbl_r[q_bidx_s];
    q_hit_s        = q_dir_s.valid && (q_dir_s.tag == q_tag_s);
    u_hit_s        = u_dir_s.valid && (u_dir_s.tag == u_tag_s);
    q_bhit_s       = q_btb_s.valid && (q_btb_s.tag == q_btag_s);
    q_rel_target_s = bp.query_pc + bp.query_ctrl.imm;
    upd_dir_s      = bp.update_valid && (u_kind_s == CF_COND);
    upd_btb_s      = bp.update_valid && (u_kind_s == CF_JALR) && bp.update_taken;
  end

  // Address bits outside the index/tag fields and the update immediate never reach a table.
  assign unused_s = ^{bp.update_ctrl.imm, bp.update_pc, bp.query_pc};

  sat_counter_update #(
    .WIDTH (CTR_BITS)
  ) u_sat_counter_update (
    .ctr      (u_dir_s.ctr),
    .taken    (bp.update_taken),
    .ctr_next (u_ctr_next_s)
  );

  // Combinational prediction from pre-update table contents.
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = 32'd0;
    if (bp.query_valid) begin
      case (q_kind_s)
        CF_JAL: begin
          pred_taken_s  = 1'b1;
          pred_target_s = q_rel_target_s;
        end
        CF_COND: begin
          pred_taken_s  = q_hit_s && q_dir_s.ctr[CTR_BITS-1];
          pred_target_s = q_rel_target_s;
        end
        CF_JALR: begin
          if (q_bhit_s) begin
            pred_taken_s  = 1'b1;
            pred_target_s = q_btb_s.target;
          end else begin
            pred_taken_s  = 1'b0;
            pred_target_s = 32'd0;
          end
        end
        default: begin
          pred_taken_s  = 1'b0;
          pred_target_s = 32'd0;
        end
      endcase
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = 32'd0;
    end
  end

  assign bp.pred_taken  = pred_taken_s;
  assign bp.pred_target = pred_target_s;
  assign bp.pred_ghr    = ghr_r;

  // Next history: misprediction recovery overrides the speculative shift.
  always_comb begin
    q_shift_s  = {ghr_r, pred_taken_s};
    u_shift_s  = {bp.update_ghr, bp.update_taken};
    ghr_next_s = ghr_r;
    if (bp.update_valid && bp.update_mispredict) begin
      if (u_kind_s == CF_COND) begin
        ghr_next_s = u_shift_s[GHR_BITS-1:0];
      end else begin
        ghr_next_s = bp.update_ghr;
      end
    end else if (bp.query_valid && (q_kind_s == CF_COND)) begin
      ghr_next_s = q_shift_s[GHR_BITS-1:0];
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else begin
      ghr_r <= ghr_next_s;
    end
  end

  // Direction table: allocate on tag miss, saturating train on hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        dir_tbl_r[i].valid <= 1'b0;
        dir_tbl_r[i].tag   <= {TAG_BITS{1'b0}};
        dir_tbl_r[i].ctr   <= CTR_WEAK_NT;
      end
    end else if (upd_dir_s) begin
      if (u_hit_s) begin
        dir_tbl_r[u_idx_s].ctr <= u_ctr_next_s;
      end else begin
        dir_tbl_r[u_idx_s].valid <= 1'b1;
        dir_tbl_r[u_idx_s].tag   <= u_tag_s;
        dir_tbl_r[u_idx_s].ctr   <= bp.update_taken ? CTR_WEAK_T : CTR_WEAK_NT;
      end
    end
  end

  // JALR target buffer: a taken JALR always overwrites its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tbl_r[i].valid  <= 1'b0;
        btb_tbl_r[i].tag    <= {TAG_BITS{1'b0}};
        btb_tbl_r[i].target <= 32'd0;
      end
    end else if (upd_btb_s) begin
      btb_tbl_r[u_bidx_s].valid  <= 1'b1;
      btb_tbl_r[u_bidx_s].tag    <= u_btag_s;
      btb_tbl_r[u_bidx_s].target <= bp.update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed plus randomized bench for branch_predictor_gshare against an arithmetic table model.
module tb_branch_predictor_gshare;
  import isa_pkg::*;

  localparam int ENTRIES     = 256;
  localparam int GHR_BITS    = 8;
  localparam int CTR_BITS    = 2;
  localparam int TAG_BITS    = 10;
  localparam int BTB_ENTRIES = 16;
  localparam int IDX_BITS    = $clog2(ENTRIES);
  localparam int BIDX        = $clog2(BTB_ENTRIES);
  localparam int HALF        = 1 << (CTR_BITS - 1);
  localparam int CMAX        = (1 << CTR_BITS) - 1;
  localparam int K_NONE = 0, K_COND = 1, K_JAL = 2, K_JALR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.GHR_BITS(GHR_BITS)) bp_if ();

  branch_predictor_gshare #(
    .ENTRIES     (ENTRIES),
    .GHR_BITS    (GHR_BITS),
    .CTR_BITS    (CTR_BITS),
    .TAG_BITS    (TAG_BITS),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  int vectors = 0;
  int miscompares = 0;

  bit          m_dv   [ENTRIES];
  int unsigned m_dtag [ENTRIES];
  int          m_dctr [ENTRIES];
  bit          m_bv   [BTB_ENTRIES];
  int unsigned m_btag [BTB_ENTRIES];
  logic [31:0] m_btgt [BTB_ENTRIES];
  int unsigned m_ghr;

  bit          e_taken;
  logic [31:0] e_target;
  int unsigned e_ghr;

  function automatic int kind_of(input decode_ctrl_t c);
    if (!c.is_branch) return K_NONE;
    if (c.funct3 == 3'b011) return K_JAL;
    if (c.funct3 == 3'b010) return K_JALR;
    return K_COND;
  endfunction

  function automatic int unsigned dir_idx(input logic [31:0] pc, input int unsigned g);
    return ((pc >> 2) % ENTRIES) ^ g;
  endfunction

  function automatic int unsigned dir_tag(input logic [31:0] pc);
    return (pc >> (2 + IDX_BITS)) % (1 << TAG_BITS);
  endfunction

  function automatic int unsigned btb_idx(input logic [31:0] pc);
    return (pc >> 2) % BTB_ENTRIES;
  endfunction

  function automatic int unsigned btb_tag(input logic [31:0] pc);
    return (pc >> (2 + BIDX)) % (1 << TAG_BITS);
  endfunction

  function automatic decode_ctrl_t mk(input int k, input logic [31:0] imm, input logic [2:0] cf3);
    decode_ctrl_t c;
    c.imm       = imm;
    c.is_branch = (k != K_NONE);
    c.funct3    = (k == K_JAL) ? 3'b011 : (k == K_JALR) ? 3'b010 : cf3;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_dv[i] = 1'b0; m_dtag[i] = 0; m_dctr[i] = HALF - 1;
    end
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_bv[i] = 1'b0; m_btag[i] = 0; m_btgt[i] = 32'd0;
    end
    m_ghr = 0;
  endtask

  task automatic model_predict();
    int unsigned i;
    e_taken  = 1'b0;
    e_target = 32'd0;
    e_ghr    = m_ghr;
    if (bp_if.query_valid) begin
      case (kind_of(bp_if.query_ctrl))
        K_COND: begin
          e_target = bp_if.query_pc + bp_if.query_ctrl.imm;
          i = dir_idx(bp_if.query_pc, m_ghr);
          e_taken = m_dv[i] && (m_dtag[i] == dir_tag(bp_if.query_pc)) && (m_dctr[i] >= HALF);
        end
        K_JAL: begin
          e_taken  = 1'b1;
          e_target = bp_if.query_pc + bp_if.query_ctrl.imm;
        end
        K_JALR: begin
          i = btb_idx(bp_if.query_pc);
          if (m_bv[i] && m_btag[i] == btb_tag(bp_if.query_pc)) begin
            e_taken  = 1'b1;
            e_target = m_btgt[i];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_commit();
    int unsigned g_next, i, ug;
    int uk;
    if (rst) begin
      model_reset();
      return;
    end
    uk = kind_of(bp_if.update_ctrl);
    ug = bp_if.update_ghr;
    g_next = m_ghr;
    if (bp_if.query_valid && kind_of(bp_if.query_ctrl) == K_COND)
      g_next = (m_ghr * 2 + e_taken) % (1 << GHR_BITS);
    if (bp_if.update_valid && bp_if.update_mispredict)
      g_next = (uk == K_COND) ? (ug * 2 + bp_if.update_taken) % (1 << GHR_BITS) : ug;
    if (bp_if.update_valid && uk == K_COND) begin
      i = dir_idx(bp_if.update_pc, ug);
      if (m_dv[i] && m_dtag[i] == dir_tag(bp_if.update_pc)) begin
        if (bp_if.update_taken) m_dctr[i] = (m_dctr[i] == CMAX) ? CMAX : m_dctr[i] + 1;
        else                    m_dctr[i] = (m_dctr[i] == 0) ? 0 : m_dctr[i] - 1;
      end else begin
        m_dv[i]   = 1'b1;
        m_dtag[i] = dir_tag(bp_if.update_pc);
        m_dctr[i] = bp_if.update_taken ? HALF : HALF - 1;
      end
    end
    if (bp_if.update_valid && uk == K_JALR && bp_if.update_taken) begin
      i = btb_idx(bp_if.update_pc);
      m_bv[i]   = 1'b1;
      m_btag[i] = btb_tag(bp_if.update_pc);
      m_btgt[i] = bp_if.update_target;
    end
    m_ghr = g_next;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_query(input bit v, input int k, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [2:0] cf3 = 3'b000);
    bp_if.query_valid = v;
    bp_if.query_ctrl  = mk(k, imm, cf3);
    bp_if.query_pc    = pc;
  endtask

  task automatic set_update(input bit v, input int k, input logic [31:0] pc, input bit tk,
                            input logic [31:0] tgt, input logic [GHR_BITS-1:0] g, input bit mis,
                            input logic [2:0] cf3 = 3'b000);
    bp_if.update_valid      = v;
    bp_if.update_ctrl       = mk(k, 32'd0, cf3);
    bp_if.update_pc         = pc;
    bp_if.update_taken      = tk;
    bp_if.update_target     = tgt;
    bp_if.update_ghr        = g;
    bp_if.update_mispredict = mis;
  endtask

  task automatic idle();
    set_query(1'b0, K_NONE, 32'd0, 32'd0);
    set_update(1'b0, K_NONE, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
  endtask

  // Fixed expected values, independent of the model.
  task automatic want(input string tag, input bit tk, input logic [31:0] tgt, input logic [7:0] g);
    #1;
    check({tag, ".taken"},  {31'd0, bp_if.pred_taken}, {31'd0, tk});
    check({tag, ".target"}, bp_if.pred_target, tgt);
    check({tag, ".ghr"},    {24'd0, bp_if.pred_ghr}, {24'd0, g});
  endtask

  task automatic step(input string tag);
    #1;
    model_predict();
    check({tag, ".m_taken"},  {31'd0, bp_if.pred_taken}, {31'd0, e_taken});
    check({tag, ".m_target"}, bp_if.pred_target, e_target);
    check({tag, ".m_ghr"},    {24'd0, bp_if.pred_ghr}, e_ghr);
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic train(input bit tk);
    idle();
    set_update(1'b1, K_COND, 32'h100, tk, 32'd0, 8'd0, 1'b0);
    step("train");
  endtask

  // Query the conditional at pc 0x100 while a JAL recovery pins GHR back to 0.
  task automatic probe(input string tag, input bit tk);
    set_query(1'b1, K_COND, 32'h100, 32'h40);
    set_update(1'b1, K_JAL, 32'h0, 1'b1, 32'd0, 8'd0, 1'b1);
    want(tag, tk, 32'h140, 8'd0);
    step(tag);
  endtask

  logic [31:0] pcs [6];

  initial begin
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300;
    pcs[3] = 32'h340; pcs[4] = 32'h500; pcs[5] = 32'h104;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    want("reset", 1'b0, 32'd0, 8'd0);
    step("reset");
    rst = 1'b0;

    set_query(1'b1, K_COND, 32'h100, 32'h40);
    want("cond_cold", 1'b0, 32'h140, 8'd0);
    step("cond_cold");
    set_query(1'b1, K_JAL, 32'h100, 32'h40);
    want("jal", 1'b1, 32'h140, 8'd0);
    step("jal");
    idle();
    want("jal_no_shift", 1'b0, 32'd0, 8'd0);

    train(1'b1); probe("ctr_10", 1'b1);
    train(1'b1); train(1'b1); probe("ctr_11", 1'b1);
    train(1'b0); probe("ctr_dn_10", 1'b1);
    train(1'b0); probe("ctr_dn_01", 1'b0);
    train(1'b0); probe("ctr_dn_00", 1'b0);
    train(1'b1); probe("ctr_sat0", 1'b0);
    train(1'b1); train(1'b1);

    idle();
    set_query(1'b1, K_COND, 32'h100, 32'h40);
    want("spec_a", 1'b1, 32'h140, 8'h00);
    step("spec_a");
    set_query(1'b1, K_COND, 32'h200, 32'h10);
    want("spec_b", 1'b0, 32'h210, 8'h01);
    step("spec_b");
    set_query(1'b1, K_COND, 32'h200, 32'h10);
    set_update(1'b1, K_COND, 32'h200, 1'b0, 32'd0, 8'h05, 1'b1);
    want("recover_q", 1'b0, 32'h210, 8'h02);
    step("recover_q");
    idle();
    want("recover", 1'b0, 32'd0, 8'h0A);
    step("recover");

    set_update(1'b1, K_JALR, 32'h300, 1'b1, 32'h8000, 8'h0A, 1'b0);
    step("btb_wr");
    idle();
    set_query(1'b1, K_JALR, 32'h300, 32'h0);
    want("btb_hit", 1'b1, 32'h8000, 8'h0A);
    step("btb_hit");
    set_query(1'b1, K_JALR, 32'h340, 32'h0);
    want("btb_alias", 1'b0, 32'd0, 8'h0A);
    step("btb_alias");
    set_query(1'b1, K_JALR, 32'h300, 32'h0);
    set_update(1'b1, K_JALR, 32'h300, 1'b1, 32'h9000, 8'h0A, 1'b0);
    want("btb_nobypass", 1'b1, 32'h8000, 8'h0A);
    step("btb_nobypass");
    idle();
    set_query(1'b1, K_JALR, 32'h300, 32'h0);
    want("btb_new", 1'b1, 32'h9000, 8'h0A);
    step("btb_new");

    idle();
    set_update(1'b1, K_COND, 32'h500, 1'b0, 32'd0, 8'd0, 1'b0);
    step("alias_wr");
    idle();
    set_update(1'b1, K_JAL, 32'h0, 1'b1, 32'd0, 8'd0, 1'b1);
    step("ghr_zero");
    probe("alias_miss", 1'b0);

    train(1'b1); train(1'b1);
    rst = 1'b1;
    idle();
    set_update(1'b1, K_COND, 32'h100, 1'b1, 32'd0, 8'd0, 1'b0);
    step("mid_reset");
    rst = 1'b0;
    idle();
    set_query(1'b1, K_COND, 32'h100, 32'h40);
    want("post_rst_cond", 1'b0, 32'h140, 8'd0);
    step("post_rst_cond");
    set_query(1'b1, K_JALR, 32'h300, 32'h0);
    want("post_rst_btb", 1'b0, 32'd0, 8'd0);
    step("post_rst_btb");

    for (int n = 0; n < 400; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'b010 || f3 == 3'b011) f3 = 3'b000;
      set_query($urandom_range(0, 3) != 0, $urandom_range(0, 3), pcs[$urandom_range(0, 5)],
                32'($urandom_range(0, 255)) << 2, f3);
      set_update($urandom_range(0, 2) != 0, $urandom_range(0, 3), pcs[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), 32'($urandom), 
                 ($urandom_range(0, 1) != 0) ? 8'(m_ghr) : 8'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, f3);
      rst = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
